gbc_vram_target: RTL and testbench

- Responder (target) end of the video RAM memory port that the GBC video memory bus drives as initiator.
- Owns the 16 KiB CGB VRAM: two 8 KiB banks, addressed by a flat 14-bit address whose bit 13 is the bank.
- Runs a post-reset clear sequence, accepts byte reads and writes, and returns read data through a fixed-latency pipeline with the port's Ready/DataReady handshake.

---
 rtl/gbc_video_pkg.sv | 16 +
 rtl/gbc_vram_array.sv | 32 +++
 rtl/gbc_vram_target.sv | 143 ++++++++++++++
 tb/tb_gbc_vram_target.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_video_pkg.sv
// Shared constants and types for the GBC video memory subsystem.
// VRAM is two 8 KiB banks addressed by a flat 14-bit byte address.
package gbc_video_pkg;

    localparam int VRAM_ADDR_W     = 14;
    localparam int VRAM_BANK_BYTES = 8192;
    localparam int VRAM_BYTES      = 16384;

    typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;

    typedef enum logic {
        CLEAR,
        SERVE
    } vram_state_e;

endpackage

// File: rtl/gbc_vram_array.sv
// Single-port synchronous byte RAM with clock enable and a registered read.
// The read register only loads on a read so it can act as a holding stage.
module gbc_vram_array #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          Clk,
    input  logic          en,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge Clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata_reg <= mem[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/gbc_vram_target.sv
// VRAM responder on the video memory bus: post-reset clear, byte read/write,
// and fixed-latency read return with Ready/DataReady handshake.
module gbc_vram_target
    import gbc_video_pkg::*;
#(
    parameter int         DEPTH          = VRAM_BYTES,
    parameter int         READ_LATENCY   = 2,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] CLEAR_VALUE    = 8'h00
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic                   ClkEn,
    input  logic [VRAM_ADDR_W-1:0] Address,
    input  logic                   Access,
    input  logic                   Write,
    input  logic                   Mask,
    input  logic [7:0]             DToTarget,
    output logic [7:0]             DToInitiator,
    output logic                   Ready,
    output logic                   DataReady
);

    localparam int             AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  LAST_ADDR   = AW'(DEPTH - 1);
    localparam vram_state_e    RESET_STATE = CLEAR_ON_RESET ? CLEAR : SERVE;

    vram_state_e              state_reg, state_next;
    logic [AW-1:0]            clear_addr_reg, clear_addr_next;
    logic                     ready_reg, ready_next;
    logic [READ_LATENCY-1:0]  vld_reg;

    logic                     ram_we, ram_re;
    logic [AW-1:0]            ram_addr;
    logic [7:0]               ram_wdata, ram_rdata;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg      <= RESET_STATE;
            clear_addr_reg <= '0;
            ready_reg      <= 1'b0;
        end else if (ClkEn) begin
            state_reg      <= state_next;
            clear_addr_reg <= clear_addr_next;
            ready_reg      <= ready_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        clear_addr_next = clear_addr_reg;
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        ram_addr        = Address[AW-1:0];
        ram_wdata       = DToTarget;
        case (state_reg)
            CLEAR: begin
                ram_we          = 1'b1;
                ram_addr        = clear_addr_reg;
                ram_wdata       = CLEAR_VALUE;
                clear_addr_next = clear_addr_reg + 1'b1;
                if (clear_addr_reg == LAST_ADDR) begin
                    state_next = SERVE;
                end
            end
            SERVE: begin
                // Masked writes are still accepted; they just never reach the array.
                ram_we = ready_reg & Access & Write & ~Mask;
                ram_re = ready_reg & Access & ~Write;
            end
            default: state_next = RESET_STATE;
        endcase
        ready_next = (state_next == SERVE);
    end

    gbc_vram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .Clk   (Clk),
        .en    (ClkEn),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // vld_reg[i] marks that the data at stage i belongs to an accepted read.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            vld_reg <= '0;
        end else if (ClkEn) begin
            vld_reg[0] <= ram_re;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    assign DataReady = vld_reg[READ_LATENCY-1];
    assign Ready     = ready_reg;

    genvar gi;
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            // The array read register is the output stage; mask it until it holds real data.
            logic have_reg;
            always_ff @(posedge Clk or negedge nReset) begin
                if (!nReset) begin
                    have_reg <= 1'b0;
                end else if (ClkEn && ram_re) begin
                    have_reg <= 1'b1;
                end
            end
            assign DToInitiator = have_reg ? ram_rdata : 8'h00;
        end else begin : g_latn
            for (gi = 0; gi < READ_LATENCY - 1; gi++) begin : g_stage
                logic [7:0] d;
                logic [7:0] q_reg;
                if (gi == 0) begin : g_src_ram
                    assign d = ram_rdata;
                end else begin : g_src_stage
                    assign d = g_stage[gi-1].q_reg;
                end
                always_ff @(posedge Clk or negedge nReset) begin
                    if (!nReset) begin
                        q_reg <= 8'h00;
                    end else if (ClkEn && vld_reg[gi]) begin
                        q_reg <= d;
                    end
                end
            end
            assign DToInitiator = g_stage[READ_LATENCY-2].q_reg;
        end

        if (AW < VRAM_ADDR_W) begin : g_addr_wrap
            logic unused_high_addr;
            assign unused_high_addr = ^Address[VRAM_ADDR_W-1:AW];
        end
    endgenerate

endmodule

// File: tb/tb_gbc_vram_target.sv
// Randomized and directed bench for gbc_vram_target against a queue-based model.
module tb_gbc_vram_target;

    localparam int         DEPTH = 64;
    localparam int         LAT   = 2;
    localparam logic [7:0] CV    = 8'hA5;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic        ClkEn = 1'b0;
    logic        Access = 1'b0;
    logic        Write = 1'b0;
    logic        Mask = 1'b0;
    logic [13:0] Address = '0;
    logic [7:0]  DToTarget = '0;
    logic [7:0]  DToInitiator, full_dout;
    logic        Ready, DataReady, full_ready, full_dr;

    gbc_vram_target #(
        .DEPTH(DEPTH), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut (
        .Clk(Clk), .nReset(nReset), .ClkEn(ClkEn), .Address(Address),
        .Access(Access), .Write(Write), .Mask(Mask), .DToTarget(DToTarget),
        .DToInitiator(DToInitiator), .Ready(Ready), .DataReady(DataReady)
    );

    gbc_vram_target #(
        .DEPTH(16384), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut_full (
        .Clk(Clk), .nReset(nReset), .ClkEn(ClkEn), .Address(Address),
        .Access(Access), .Write(Write), .Mask(Mask), .DToTarget(DToTarget),
        .DToInitiator(full_dout), .Ready(full_ready), .DataReady(full_dr)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte array, clear progress, queue of pending read results.
    typedef struct {
        logic [7:0] data;
        int         due;
    } pend_t;

    logic [7:0] ref_mem [DEPTH];
    pend_t      pend[$];
    logic [7:0] seen[$];
    int         ecount, clear_n;
    logic       m_ready, m_dr;
    logic [7:0] m_dout;

    task automatic model_reset();
        pend.delete();
        ecount  = 0;
        clear_n = 0;
        m_ready = 1'b0;
        m_dr    = 1'b0;
        m_dout  = 8'h00;
    endtask

    task automatic cycle(input logic en, input logic acc, input logic wr, input logic msk,
                         input logic [13:0] a, input logic [7:0] d);
        ClkEn = en; Access = acc; Write = wr; Mask = msk; Address = a; DToTarget = d;
        @(posedge Clk);
        if (en) begin
            int ea;
            ea = int'(a) % DEPTH;
            ecount++;
            if (clear_n < DEPTH) begin
                ref_mem[clear_n] = CV;
                clear_n++;
            end else if (acc && m_ready) begin
                if (wr) begin
                    if (!msk) ref_mem[ea] = d;
                    $display("%0t write addr=%h data=%h mask=%0d", $time, a, d, msk);
                end else begin
                    pend.push_back('{data: ref_mem[ea], due: ecount + LAT - 1});
                    $display("%0t read  addr=%h expect=%h", $time, a, ref_mem[ea]);
                end
            end
            m_ready = (clear_n == DEPTH);
            m_dr    = 1'b0;
            if (pend.size() > 0 && pend[0].due == ecount) begin
                m_dr   = 1'b1;
                m_dout = pend[0].data;
                void'(pend.pop_front());
            end
        end
        #1;
        check("ready", 32'(Ready), 32'(m_ready));
        check("data_ready", 32'(DataReady), 32'(m_dr));
        check("dout", 32'(DToInitiator), 32'(m_dout));
        if (en && DataReady) seen.push_back(DToInitiator);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
    endtask

    task automatic check_seen(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 'x;
        if (seen.size() > 0) got = seen.pop_front();
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic do_reset(input int hold);
        ClkEn = 1'b0; Access = 1'b0;
        nReset = 1'b0;
        model_reset();
        #1;
        check("rst_ready", 32'(Ready), 32'(1'b0));
        check("rst_data_ready", 32'(DataReady), 32'(1'b0));
        check("rst_dout", 32'(DToInitiator), 32'(8'h00));
        repeat (hold) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b1;
    endtask

    // Requests during the clear are random and must all be ignored.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (Ready !== 1'b1 && n < 200) begin
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0, 14'($urandom), 8'($urandom));
            n++;
        end
        check(tag, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(2);
        wait_clear("clear_len");

        seen.delete();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'(i), 8'h0);
        idle(3);
        check("rd_all_count", 32'(seen.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) check_seen("rd_all_val", CV);

        seen.delete();
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'h0010, 8'h11);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 14'h0010, 8'hFF);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0010, 8'h00);
        idle(3);
        check_seen("masked_write", 8'h11);

        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'(i), 8'(8'h10 + i));
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'(i), 8'h0);
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 14'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 14'h0, 8'h0);
        end
        for (int i = 0; i < 4; i++) check_seen("b2b_order", 8'(8'h10 + i));

        cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'h0005, 8'h55);
        seen.delete();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0005, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'h0005, 8'h66);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0005, 8'h00);
        idle(3);
        check_seen("rd_before_wr", 8'h55);
        check_seen("rd_after_wr", 8'h66);

        do_reset(2);
        idle(20);
        do_reset(3);
        wait_clear("clear_restart");

        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0005, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0006, 8'h00);
        check("inflight_dr_before_rst", 32'(DataReady), 32'(1'b1));
        do_reset(3);
        wait_clear("clear_after_flush");

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(3) != 0, 1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                  14'($urandom), 8'($urandom));
        end
        idle(4);
        check("rand_drained", 32'(pend.size()), 32'(0));

        begin
            int n;
            n = 0;
            while (full_ready !== 1'b1 && n < 20000) begin
                cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
                n++;
            end
            check("full_ready", 32'(full_ready), 32'(1'b1));
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 14'h2001, 8'h3C);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h2001, 8'h00);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 14'h0001, 8'h00);
        check("bank1_dr", 32'(full_dr), 32'(1'b1));
        check("bank1_data", 32'(full_dout), 32'(8'h3C));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
        check("bank0_dr", 32'(full_dr), 32'(1'b1));
        check("bank0_data", 32'(full_dout), 32'(CV));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 14'h0, 8'h0);
        check("bank_dr_low", 32'(full_dr), 32'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
